// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), one bit per
// clock, LSB first. The datapath is a single full-subtractor cell whose borrow
// is kept in a register between bit slices.
//
// A start/busy/done handshake frames each operation. The operands are captured
// when start is accepted in IDLE or DONE. The operation then takes WIDTH RUN
// cycles and one DONE cycle. When start is held high in DONE, the next
// operation begins with no idle cycle in between.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous reset, active-high; aborts any operation
//   start  in   1      request: sample a/b and begin (ignored while busy)
//   a      in   WIDTH  minuend, sampled on start accept
//   b      in   WIDTH  subtrahend, sampled on start accept
//   busy   out  1      high while bits are being processed (state RUN)
//   done   out  1      one-cycle pulse, diff/bout valid (state DONE)
//   diff   out  WIDTH  (a - b) mod 2^WIDTH, held until the next result
//   bout   out  1      final borrow, 1 iff a < b (unsigned)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  // Result bits collected so far. The newest bit enters at the top. Only
  // WIDTH-1 bits are stored, because the last bit goes straight to diff.
  logic [WIDTH-2:0] res;
  logic             borrow;
  logic [CW-1:0]    count;

  logic             x;
  logic             y;
  logic             d;
  logic             borrow_nxt;
  logic [WIDTH-1:0] res_sh;

  // Full-subtractor difference bit.
  function automatic logic sub_diff(input logic xi, input logic yi, input logic ci);
    return xi ^ yi ^ ci;
  endfunction

  // Full-subtractor borrow out.
  // Borrow when x=0,y=1, or when x==y and a borrow is pending.
  function automatic logic sub_borrow(input logic xi, input logic yi, input logic ci);
    return (~xi & yi) | (~(xi ^ yi) & ci);
  endfunction

  always_comb begin
    x          = sa[0];
    y          = sb[0];
    d          = sub_diff(x, y, borrow);
    borrow_nxt = sub_borrow(x, y, borrow);
    res_sh     = {d, res};
  end

  // Control and datapath share one clocked block.
  // busy and done are registered alongside the state, so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= a;
            sb     <= b;
            res    <= '0;
            borrow <= 1'b0;
            count  <= '0;
            state  <= RUN;
            busy   <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          res    <= res_sh[WIDTH-1:1];
          borrow <= borrow_nxt;
          count  <= count + CW'(1);
          if (count == LAST) begin
            diff  <= res_sh;
            bout  <= borrow_nxt;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= a;
            sb     <= b;
            res    <= '0;
            borrow <= 1'b0;
            count  <= '0;
            state  <= RUN;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed testbench for serial_subtractor with WIDTH=8. It checks:
//   - reset state
//   - cycle-exact busy/done timing
//   - wrap-around and edge operands
//   - start ignored while RUN
//   - back-to-back operation with start held high
//   - abort by reset during RUN
//   - a strided sweep of operand pairs against a reference model
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  int total  = 0;
  int passed = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full cycle-accurate check of one operation, starting from IDLE.
  // The operands are scrambled after the accept edge to show they are not re-sampled.
  task automatic op_full(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input string tag);
    start = 1'b1; a = av; b = bv;
    tick;                              // accept edge k
    start = 1'b0; a = ~av; b = ~bv;
    for (int i = 0; i < 8; i++) begin  // after edges k .. k+7
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " done-early"}, 32'(done), 32'd0);
      tick;
    end
    chk({tag, " done"}, 32'(done), 32'd1);     // after edge k+8
    chk({tag, " busy-in-done"}, 32'(busy), 32'd0);
    chk({tag, " diff"}, 32'(diff), 32'(ed));
    chk({tag, " bout"}, 32'(bout), 32'(eb));
    tick;
    chk({tag, " done-pulse"}, 32'(done), 32'd0);
    chk({tag, " diff-hold"}, 32'(diff), 32'(ed));
  endtask

  // Lighter check used by the sweep. The wait for done is bounded.
  task automatic op_quick(input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] ed;
    logic       eb;
    int         n;
    ed = av - bv;
    eb = (av < bv);
    start = 1'b1; a = av; b = bv;
    tick;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    n = 0;
    while (!done && n < 20) begin
      tick;
      n++;
    end
    chk("sweep latency", 32'(n), 32'd8);
    chk("sweep diff", 32'(diff), 32'(ed));
    chk("sweep bout", 32'(bout), 32'(eb));
    tick;
  endtask

  initial begin
    logic seen_done;

    // Reset
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    tick;
    start = 1'b1; a = 8'd7; b = 8'd3;  // start during reset must be ignored
    tick;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", 32'(diff), 32'd0);
    chk("reset bout", 32'(bout), 32'd0);
    start = 1'b0; rst = 1'b0;
    tick;
    chk("idle busy", 32'(busy), 32'd0);

    // Basic, wrap-around and edge operands
    op_full(8'd100, 8'd37,  8'd63,   1'b0, "100-37");
    op_full(8'd5,   8'd9,   8'hFC,   1'b1, "5-9");
    op_full(8'd0,   8'd1,   8'hFF,   1'b1, "0-1");
    op_full(8'd255, 8'd255, 8'd0,    1'b0, "255-255");
    op_full(8'd0,   8'd0,   8'd0,    1'b0, "0-0");
    op_full(8'd255, 8'd0,   8'd255,  1'b0, "255-0");
    op_full(8'd0,   8'd255, 8'd1,    1'b1, "0-255");

    // start and new operands during RUN are ignored
    start = 1'b1; a = 8'd100; b = 8'd37;
    tick;
    a = 8'd1; b = 8'd2;
    for (int i = 0; i < 6; i++) tick;  // start stays high through the RUN edges
    start = 1'b0;
    tick; tick;                        // after edge k+8
    chk("midrun done", 32'(done), 32'd1);
    chk("midrun diff", 32'(diff), 32'd63);
    chk("midrun bout", 32'(bout), 32'd0);
    tick;
    chk("midrun idle", 32'(busy), 32'd0);

    // start held high: a result every 9 cycles
    start = 1'b1; a = 8'd50; b = 8'd20;
    tick;
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i < 8; i++) begin
        tick;
        chk("b2b busy", 32'(busy), 32'd1);
      end
      tick;
      chk("b2b done", 32'(done), 32'd1);
      chk("b2b busy-low", 32'(busy), 32'd0);
      chk("b2b diff", 32'(diff), 32'd30);
      if (r == 2) start = 1'b0;
      tick;
      chk("b2b restart", 32'(busy), (r == 2) ? 32'd0 : 32'd1);
      chk("b2b done-clr", 32'(done), 32'd0);
    end

    // Reset in the middle of RUN aborts the operation without a done pulse
    start = 1'b1; a = 8'd200; b = 8'd55;
    tick;
    start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort diff", 32'(diff), 32'd0);
    chk("abort bout", 32'(bout), 32'd0);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen_done |= done;
      tick;
    end
    chk("abort no-done", 32'(seen_done), 32'd0);
    op_full(8'd200, 8'd55, 8'd145, 1'b0, "post-abort");

    // Strided sweep against the reference model
    for (int ia = 0; ia < 256; ia += 17)
      for (int ib = 3; ib < 256; ib += 23)
        op_quick(8'(ia), 8'(ib));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
